// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared types for the EX-stage ALU with RV32M multiply/divide.
//   alu_op_e  - decoded operation (base codes 0..9, M-extension 10..17, invalid 31)
//   AluOp*    - aluOP field encodings from the main decoder
//   state_e   - handshake FSM states
//   is_md_op  - true for any op that needs the iterative unit
package alu_md_pkg;

  typedef enum logic [4:0] {
    OpAdd     = 5'd0,
    OpSub     = 5'd1,
    OpSll     = 5'd2,
    OpSlt     = 5'd3,
    OpSltu    = 5'd4,
    OpXor     = 5'd5,
    OpSrl     = 5'd6,
    OpSra     = 5'd7,
    OpOr      = 5'd8,
    OpAnd     = 5'd9,
    OpMul     = 5'd10,
    OpMulh    = 5'd11,
    OpMulhsu  = 5'd12,
    OpMulhu   = 5'd13,
    OpDiv     = 5'd14,
    OpDivu    = 5'd15,
    OpRem     = 5'd16,
    OpRemu    = 5'd17,
    OpInvalid = 5'd31
  } alu_op_e;

  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpArith  = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic is_md_op(alu_op_e op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/alu_md_exec_md_iter.sv
// md_iter: iterative multiply/divide datapath, one bit per cycle.
//   clk, rst  - clock, synchronous active-high reset (aborts any op in flight)
//   start     - load operands and begin an XLEN-step operation
//   op        - M-extension op, sampled on start
//   op_a/op_b - operands, sampled on start
//   done      - high in the cycle of the last step; result is valid alongside it
//   result    - sign-corrected result, combinational from the final step
// Divide-by-zero and signed overflow are resolved by the caller and never started here.
module md_iter import alu_md_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // acc holds the product high half / partial remainder; lo holds the
  // multiplier being consumed / dividend shifting out while quotient shifts in.
  logic [XLEN-1:0]  acc_q, acc_d, lo_q, lo_d, mag_b_q, mag_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic             neg_a_q, neg_a_d, neg_r_q, neg_r_d;

  logic             sign_a, sign_b, is_mul;
  logic [XLEN-1:0]  mag_a_in, mag_b_in;
  logic [XLEN-1:0]  addend, mul_acc, mul_lo, div_acc, div_lo, acc_n, lo_n;
  logic [XLEN:0]    mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]  quo_s, rem_s;

  assign sign_a   = (op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem}) && op_a[XLEN-1];
  assign sign_b   = (op inside {OpMul, OpMulh, OpDiv, OpRem}) && op_b[XLEN-1];
  assign mag_a_in = sign_a ? -op_a : op_a;
  assign mag_b_in = sign_b ? -op_b : op_b;
  assign is_mul   = op_q inside {OpMul, OpMulh, OpMulhsu, OpMulhu};

  // Shift-add multiply step: add multiplicand if lsb set, shift right.
  assign addend  = lo_q[0] ? mag_b_q : {XLEN{1'b0}};
  assign mul_sum = {1'b0, acc_q} + {1'b0, addend};
  assign mul_acc = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

  // Restoring divide step: shift in next dividend bit, try subtract.
  assign div_sh   = {acc_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, mag_b_q};
  assign div_acc  = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
  assign div_lo   = {lo_q[XLEN-2:0], ~div_diff[XLEN]};

  assign acc_n = is_mul ? mul_acc : div_acc;
  assign lo_n  = is_mul ? mul_lo  : div_lo;

  assign prod   = {acc_n, lo_n};
  assign prod_s = neg_r_q ? -prod : prod;
  assign quo_s  = neg_r_q ? -lo_n : lo_n;
  assign rem_s  = neg_a_q ? -acc_n : acc_n;

  assign done = (cnt_q == CNT_W'(1));

  always_comb begin
    result = '0;
    case (op_q)
      OpMul:                      result = prod_s[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  result = prod_s[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              result = quo_s;
      OpRem, OpRemu:              result = rem_s;
      default:                    result = '0;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    lo_d    = lo_q;
    mag_b_d = mag_b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_r_d = neg_r_q;
    if (start) begin
      op_d    = op;
      acc_d   = '0;
      cnt_d   = CNT_W'(XLEN);
      neg_a_d = sign_a;
      neg_r_d = sign_a ^ sign_b;
      if (op inside {OpMul, OpMulh, OpMulhsu, OpMulhu}) begin
        lo_d    = mag_b_in;
        mag_b_d = mag_a_in;
      end else begin
        lo_d    = mag_a_in;
        mag_b_d = mag_b_in;
      end
    end else if (cnt_q != '0) begin
      acc_d = acc_n;
      lo_d  = lo_n;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      lo_q    <= '0;
      mag_b_q <= '0;
      cnt_q   <= '0;
      op_q    <= OpInvalid;
      neg_a_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mag_b_q <= mag_b_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_r_q <= neg_r_d;
    end
  end

endmodule

// File: rtl/alu_md_exec.sv
// alu_md_exec: EX-stage ALU with RV32M multiply/divide behind a valid/ready handshake.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - request handshake
//   aluOP, OP_f7, f7_m,
//   funct3               - operation select fields
//   op_a, op_b           - operands (rs1, rs2/imm)
//   out_valid/out_ready  - result handshake
//   result, zero,
//   illegal              - registered result, result==0, invalid-op flag
// Base ops and divide corner cases complete with latency 1; other M-ops take XLEN+1.
module alu_md_exec import alu_md_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter bit          MD_EN = 1'b1,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluOP,
  input  logic [1:0]      OP_f7,
  input  logic            f7_m,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d, illegal_q, illegal_d;

  alu_op_e         op_dec;
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, md_result;
  logic            div_zero, div_ovf, md_slow, md_start, md_done, accept;

  // Decode
  always_comb begin
    op_dec = OpInvalid;
    case (aluOP)
      AluOpAdd: op_dec = OpAdd;
      AluOpBranch: begin
        casez (funct3)
          3'b00?:  op_dec = OpSub;
          3'b10?:  op_dec = OpSlt;
          3'b11?:  op_dec = OpSltu;
          default: op_dec = OpInvalid;
        endcase
      end
      AluOpArith: begin
        if (MD_EN && OP_f7[1] && f7_m) begin
          case (funct3)
            3'b000:  op_dec = OpMul;
            3'b001:  op_dec = OpMulh;
            3'b010:  op_dec = OpMulhsu;
            3'b011:  op_dec = OpMulhu;
            3'b100:  op_dec = OpDiv;
            3'b101:  op_dec = OpDivu;
            3'b110:  op_dec = OpRem;
            default: op_dec = OpRemu;
          endcase
        end else begin
          case (funct3)
            3'b000:  op_dec = (&OP_f7) ? OpSub : OpAdd;
            3'b001:  op_dec = OpSll;
            3'b010:  op_dec = OpSlt;
            3'b011:  op_dec = OpSltu;
            3'b100:  op_dec = OpXor;
            3'b101:  op_dec = OP_f7[0] ? OpSra : OpSrl;
            3'b110:  op_dec = OpOr;
            default: op_dec = OpAnd;
          endcase
        end
      end
      default: op_dec = OpInvalid;
    endcase
  end

  assign shamt    = op_b[ShW-1:0];
  assign div_zero = (op_dec inside {OpDiv, OpDivu, OpRem, OpRemu}) && (op_b == '0);
  assign div_ovf  = (op_dec inside {OpDiv, OpRem}) && (op_a == MinVal) && (&op_b);
  // Divide corners are answered directly; everything else in the M group iterates.
  assign md_slow  = is_md_op(op_dec) && !div_zero && !div_ovf;

  // Single-cycle results, including the divide corner cases.
  always_comb begin
    alu_res = '0;
    case (op_dec)
      OpAdd:         alu_res = op_a + op_b;
      OpSub:         alu_res = op_a - op_b;
      OpSll:         alu_res = op_a << shamt;
      OpSlt:         alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OpSltu:        alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OpXor:         alu_res = op_a ^ op_b;
      OpSrl:         alu_res = op_a >> shamt;
      OpSra:         alu_res = $signed(op_a) >>> shamt;
      OpOr:          alu_res = op_a | op_b;
      OpAnd:         alu_res = op_a & op_b;
      OpDiv, OpDivu: alu_res = div_zero ? {XLEN{1'b1}} : op_a; // overflow quotient is MIN = op_a
      OpRem, OpRemu: alu_res = div_zero ? op_a : '0;
      default:       alu_res = '0;
    endcase
  end

  if (MD_EN) begin : g_md
    md_iter #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
    ) u_md_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .op     (op_dec),
      .op_a   (op_a),
      .op_b   (op_b),
      .done   (md_done),
      .result (md_result)
    );
  end else begin : g_no_md
    assign md_done   = 1'b0;
    assign md_result = '0;
  end

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    md_start  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && out_ready) state_d = StIdle;
        if (accept) begin
          if (md_slow) begin
            md_start = 1'b1;
            state_d  = StCalc;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (op_dec == OpInvalid);
            state_d   = StDone;
          end
        end
      end
      StCalc: begin
        if (md_done) begin
          result_d  = md_result;
          zero_d    = (md_result == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
